// File: rtl/alu_mc_param_if.sv
// alu_mc_param_if: request/result bundle between an ALU client and alu_mc_param
interface alu_mc_param_if #(parameter int WIDTH = 32);
  logic start;
  logic [WIDTH-1:0] e1;
  logic [WIDTH-1:0] e2;
  logic [3:0] sel;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_hi;
  logic zf;
  logic cf;
  logic dz;
  logic busy;
  logic done;
  modport master (output start, e1, e2, sel, input res, res_hi, zf, cf, dz, busy, done);
  modport slave (input start, e1, e2, sel, output res, res_hi, zf, cf, dz, busy, done);
endinterface

// File: rtl/alu_mc_param.sv
// alu_mc_param: registered ALU with iterative shift-add multiply and restoring divide
module alu_mc_param #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  alu_mc_param_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0] b;
  logic is_mul;
  logic [WIDTH-1:0] s_res, s_hi;
  logic s_cf, s_dz, multi;
  logic [WIDTH:0] sum, diff, m_sum, sh, d_diff;
  logic [2*WIDTH-1:0] p_nx;
  // single-cycle results and the decision whether the op needs the iterative unit
  always_comb begin
    sum = {1'b0, bus.e1} + {1'b0, bus.e2};
    diff = {1'b0, bus.e1} - {1'b0, bus.e2};
    s_res = '0;
    s_hi = '0;
    s_cf = 1'b0;
    s_dz = 1'b0;
    multi = 1'b0;
    case (bus.sel)
      4'b0000: s_res = bus.e1 & bus.e2;
      4'b0001: s_res = bus.e1 | bus.e2;
      4'b0010: s_res = bus.e1 ^ bus.e2;
      4'b0011: s_res = ~(bus.e1 & bus.e2);
      4'b0100: {s_cf, s_res} = sum;
      4'b0101: {s_cf, s_res} = diff;
      4'b0110: multi = 1'b1;
      4'b0111: begin
        multi = bus.e2 != '0;
        s_res = '1;
        s_hi = bus.e1;
        s_dz = bus.e2 == '0;
      end
      4'b1000: s_res = WIDTH'(bus.e1 < bus.e2);
      4'b1001: s_res = WIDTH'(bus.e1 == bus.e2);
      default: s_res = '0;
    endcase
  end
  // one iteration: p holds {acc, multiplier} for MUL or {remainder, dividend/quotient} for DIV
  always_comb begin
    m_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, b} : '0);
    sh = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    d_diff = sh - {1'b0, b};
    p_nx = is_mul ? {m_sum, p[WIDTH-1:1]}
         : d_diff[WIDTH] ? {sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
         : {d_diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
  end
  // control FSM with registered results; start is honoured in IDLE and DONE only
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      p <= '0;
      b <= '0;
      is_mul <= 1'b0;
      bus.res <= '0;
      bus.res_hi <= '0;
      bus.zf <= 1'b1;
      bus.cf <= 1'b0;
      bus.dz <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else if (state == CALC) begin
      p <= p_nx;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) begin
        state <= DONE;
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
        bus.res <= p_nx[WIDTH-1:0];
        bus.res_hi <= p_nx[2*WIDTH-1:WIDTH];
        bus.zf <= p_nx[WIDTH-1:0] == '0;
        bus.cf <= 1'b0;
        bus.dz <= 1'b0;
      end
    end else if (bus.start) begin
      b <= bus.e2;
      is_mul <= bus.sel == 4'b0110;
      cnt <= '0;
      p <= {{WIDTH{1'b0}}, bus.e1};
      if (multi) begin
        state <= CALC;
        bus.busy <= 1'b1;
        bus.done <= 1'b0;
      end else begin
        state <= DONE;
        bus.done <= 1'b1;
        bus.res <= s_res;
        bus.res_hi <= s_hi;
        bus.zf <= s_res == '0;
        bus.cf <= s_cf;
        bus.dz <= s_dz;
      end
    end else begin
      state <= IDLE;
      bus.done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_mc_param.sv
// tb_alu_mc_param: directed vector table plus hand sequences for multi-cycle corners
module tb_alu_mc_param;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  alu_mc_param_if #(.WIDTH(W)) bus ();
  alu_mc_param #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic [3:0] sel;
    logic [W-1:0] a, b, r, h;
    logic z, c, d;
    int lat;
  } vec_t;
  vec_t v[19];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_n);
    bus.start = 1'b1;
    bus.sel = s;
    bus.e1 = a;
    bus.e2 = b;
    tick;
    bus.start = 1'b0;
    bus.sel = ~s;
    bus.e1 = ~a;
    bus.e2 = ~b;
    lat = 1;
    busy_n = 0;
    while (!bus.done && lat < 3 * W) begin
      if (bus.busy) busy_n++;
      tick;
      lat++;
    end
  endtask
  initial begin
    int lat, bn, extra;
    v[0]  = '{4'b0000, 8'hF0, 8'h3C, 8'h30, 8'h00, 0, 0, 0, 1};
    v[1]  = '{4'b0001, 8'hF0, 8'h0F, 8'hFF, 8'h00, 0, 0, 0, 1};
    v[2]  = '{4'b0010, 8'hAA, 8'hAA, 8'h00, 8'h00, 1, 0, 0, 1};
    v[3]  = '{4'b0011, 8'hF0, 8'h0F, 8'hFF, 8'h00, 0, 0, 0, 1};
    v[4]  = '{4'b0100, 8'hF0, 8'h20, 8'h10, 8'h00, 0, 1, 0, 1};
    v[5]  = '{4'b0100, 8'hFF, 8'h01, 8'h00, 8'h00, 1, 1, 0, 1};
    v[6]  = '{4'b0101, 8'h05, 8'h05, 8'h00, 8'h00, 1, 0, 0, 1};
    v[7]  = '{4'b0101, 8'h03, 8'h05, 8'hFE, 8'h00, 0, 1, 0, 1};
    v[8]  = '{4'b0110, 8'hFF, 8'hFF, 8'h01, 8'hFE, 0, 0, 0, 9};
    v[9]  = '{4'b0110, 8'h10, 8'h10, 8'h00, 8'h01, 1, 0, 0, 9};
    v[10] = '{4'b0110, 8'h0D, 8'h0B, 8'h8F, 8'h00, 0, 0, 0, 9};
    v[11] = '{4'b0111, 8'd200, 8'd7, 8'd28, 8'd4, 0, 0, 0, 9};
    v[12] = '{4'b0111, 8'd200, 8'd0, 8'hFF, 8'd200, 0, 0, 1, 1};
    v[13] = '{4'b0111, 8'd5, 8'd9, 8'd0, 8'd5, 1, 0, 0, 9};
    v[14] = '{4'b1000, 8'd3, 8'd5, 8'd1, 8'd0, 0, 0, 0, 1};
    v[15] = '{4'b1000, 8'd5, 8'd3, 8'd0, 8'd0, 1, 0, 0, 1};
    v[16] = '{4'b1001, 8'h3C, 8'h3C, 8'd1, 8'd0, 0, 0, 0, 1};
    v[17] = '{4'b1100, 8'hFF, 8'h01, 8'd0, 8'd0, 1, 0, 0, 1};
    v[18] = '{4'b1111, 8'hFF, 8'hFF, 8'd0, 8'd0, 1, 0, 0, 1};
    bus.start = 1'b0;
    bus.sel = '0;
    bus.e1 = '0;
    bus.e2 = '0;
    tick;
    tick;
    rst = 1'b0;
    chk("reset res", bus.res, 0);
    chk("reset res_hi", bus.res_hi, 0);
    chk("reset zf", bus.zf, 1);
    chk("reset cf", bus.cf, 0);
    chk("reset dz", bus.dz, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    for (int i = 0; i < 19; i++) begin
      run_op(v[i].sel, v[i].a, v[i].b, lat, bn);
      chk($sformatf("v%0d latency", i), lat, v[i].lat);
      chk($sformatf("v%0d busy cycles", i), bn, v[i].lat == 1 ? 0 : W);
      chk($sformatf("v%0d busy at done", i), bus.busy, 0);
      chk($sformatf("v%0d res", i), bus.res, v[i].r);
      chk($sformatf("v%0d res_hi", i), bus.res_hi, v[i].h);
      chk($sformatf("v%0d zf", i), bus.zf, v[i].z);
      chk($sformatf("v%0d cf", i), bus.cf, v[i].c);
      chk($sformatf("v%0d dz", i), bus.dz, v[i].d);
    end
    tick;
    chk("done pulse width", bus.done, 0);
    chk("hold res after done", bus.res, 0);
    // MUL with a start pulse mid-calculation that must be ignored
    bus.start = 1'b1;
    bus.sel = 4'b0110;
    bus.e1 = 8'hFF;
    bus.e2 = 8'hFF;
    tick;
    bus.start = 1'b0;
    tick;
    tick;
    bus.start = 1'b1;
    bus.sel = 4'b0100;
    bus.e1 = 8'h01;
    bus.e2 = 8'h01;
    tick;
    bus.start = 1'b0;
    lat = 4;
    while (!bus.done && lat < 3 * W) begin
      tick;
      lat++;
    end
    chk("busy-start latency", lat, 9);
    chk("busy-start res", bus.res, 8'h01);
    chk("busy-start res_hi", bus.res_hi, 8'hFE);
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (bus.done) extra++;
    end
    chk("busy-start extra done", extra, 0);
    // reset in the middle of a MUL aborts it
    run_op(4'b0100, 8'h10, 8'h20, lat, bn);
    chk("pre-abort res", bus.res, 8'h30);
    bus.start = 1'b1;
    bus.sel = 4'b0110;
    bus.e1 = 8'h0D;
    bus.e2 = 8'h0B;
    tick;
    bus.start = 1'b0;
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort res", bus.res, 0);
    chk("abort res_hi", bus.res_hi, 0);
    chk("abort zf", bus.zf, 1);
    chk("abort busy", bus.busy, 0);
    chk("abort done", bus.done, 0);
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.done || bus.busy) extra++;
      tick;
    end
    chk("abort no done", extra, 0);
    run_op(4'b0100, 8'h07, 8'h08, lat, bn);
    chk("post-abort latency", lat, 1);
    chk("post-abort res", bus.res, 8'h0F);
    // back-to-back: start held through the DONE cycle
    bus.start = 1'b1;
    bus.sel = 4'b0100;
    bus.e1 = 8'h10;
    bus.e2 = 8'h20;
    tick;
    chk("b2b first done", bus.done, 1);
    chk("b2b first res", bus.res, 8'h30);
    bus.sel = 4'b1001;
    bus.e1 = 8'h3C;
    bus.e2 = 8'h3C;
    tick;
    bus.start = 1'b0;
    chk("b2b second done", bus.done, 1);
    chk("b2b second res", bus.res, 8'h01);
    chk("b2b second zf", bus.zf, 0);
    tick;
    chk("b2b idle done", bus.done, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
